// File: rtl/spi_ram_master.sv
// spi_ram_master: turns one-word host requests into the SPI wrapper's two-frame command sequences.
// Optional feature: define SPI_ADDR_CACHE_EN to skip address frames that repeat the cached address.
module spi_ram_master #(
  parameter int ADDR_SIZE  = 8,
  parameter int MISO_LAT   = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 ss_n,
  output logic                 MOSI,
  input  logic                 MISO
);
  localparam int FW = ADDR_SIZE + 3;
  localparam int CW = $clog2(FW + 16);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TURN, CAPTURE, GAP} state_t;

  state_t               state_q, state_d;
  logic                 isWrite_q, isWrite_d;
  logic                 dataPhase_q, dataPhase_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-2:0] rx_q, rx_d;
  logic [ADDR_SIZE-1:0] rspData_q, rspData_d;
  logic [FW-1:0]        shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rspValid_q, rspValid_d;
  logic                 ssN_q, ssN_d;
  logic                 mosi_q, mosi_d;
  logic                 cacheHit;
  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload;

  // cmd[1] selects read, cmd[0] selects the data frame; read-data frames carry a zero payload
  assign cmd     = {~isWrite_q, dataPhase_q};
  assign payload = dataPhase_q ? (isWrite_q ? wdata_q : '0) : addr_q;

`ifdef SPI_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] wrCacheAddr_q, rdCacheAddr_q;
  logic                 wrCacheValid_q, rdCacheValid_q;
  logic                 addrFrameDone;

  assign addrFrameDone = (state_q == SHIFT) && (cnt_q == CW'(FW - 1)) && !dataPhase_q;
  assign cacheHit = req_write ? (wrCacheValid_q && (wrCacheAddr_q == req_addr))
                              : (rdCacheValid_q && (rdCacheAddr_q == req_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrCacheAddr_q  <= '0;
      rdCacheAddr_q  <= '0;
      wrCacheValid_q <= 1'b0;
      rdCacheValid_q <= 1'b0;
    end else if (addrFrameDone) begin
      if (isWrite_q) begin
        wrCacheAddr_q  <= addr_q;
        wrCacheValid_q <= 1'b1;
      end else begin
        rdCacheAddr_q  <= addr_q;
        rdCacheValid_q <= 1'b1;
      end
    end
  end
`else
  assign cacheHit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    isWrite_d   = isWrite_q;
    dataPhase_d = dataPhase_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    rspData_d   = rspData_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rspValid_d  = 1'b0;
    ssN_d       = 1'b1;
    mosi_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          isWrite_d   = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          dataPhase_d = cacheHit;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        shift_d = {cmd[1], cmd, payload};
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        ssN_d   = 1'b0;
        mosi_d  = shift_q[FW-1];
        shift_d = {shift_q[FW-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(FW - 1)) begin
          cnt_d   = '0;
          state_d = (!isWrite_q && dataPhase_q) ? TURN : GAP;
        end
      end
      TURN: begin
        ssN_d = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MISO_LAT - 1)) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        ssN_d = 1'b0;
        rx_d  = {rx_q[ADDR_SIZE-3:0], MISO};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ADDR_SIZE - 1)) begin
          rspData_d  = {rx_q, MISO};
          rspValid_d = 1'b1;
          cnt_d      = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (!dataPhase_q) begin
            dataPhase_d = 1'b1;
            state_d     = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ss_n and MOSI are registered, so they trail the state by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      isWrite_q   <= 1'b0;
      dataPhase_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_q        <= '0;
      rspData_q   <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      rspValid_q  <= 1'b0;
      ssN_q       <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      isWrite_q   <= isWrite_d;
      dataPhase_q <= dataPhase_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      rspData_q   <= rspData_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rspValid_q  <= rspValid_d;
      ssN_q       <= ssN_d;
      mosi_q      <= mosi_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ss_n      = ssN_q;
  assign MOSI      = mosi_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspData_q;

endmodule
